// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int X0_IDX         = 0;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs from ID/EX/MEM and the register enable/flush bundle back to the pipe.
interface pipeline_stall_controller_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
);
  logic [REG_ADDR_W-1:0]  id_rs1;
  logic [REG_ADDR_W-1:0]  id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic                   ex_mem_read;
  logic [REG_ADDR_W-1:0]  ex_rd;
  logic                   ex_branch_taken;
  logic                   ex_mc_start;
  logic                   mc_done;
  logic                   mem_req;
  logic                   mem_ready;

  logic                   pc_en;
  logic                   if_id_en;
  logic                   id_ex_en;
  logic                   ex_mem_en;
  logic                   mem_wb_en;
  logic                   if_id_flush;
  logic                   id_ex_flush;
  logic                   mem_wb_flush;
  logic [1:0]             ctrl_state;
  logic                   mc_timeout;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic [FLUSH_CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, ex_mc_start, mc_done, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush,
           ctrl_state, mc_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, ex_mc_start, mc_done, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush,
           ctrl_state, mc_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction actually reads.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  output logic                  o_hazard
);
  logic w_rd_live;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never produces a dependency.
  assign w_rd_live = (i_ex_rd != REG_ADDR_W'(X0_IDX));
  assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_hazard  = i_ex_mem_read && w_rd_live && (w_rs1_hit || w_rs2_hit);
endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline enable/flush sequencer: load-use stalls, multicycle and memory freezes,
// branch squashes, plus saturating stall/flush counters and a sticky multicycle timeout.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MC_TIMEOUT  = 64,
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
) (
  input logic                        clk,
  input logic                        reset,
  pipeline_stall_controller_if.slave bus
);
  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_MC_BUSY  = MC_BUSY;
  localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
  localparam int         MC_W       = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_TIMEOUT - 1);

  logic [1:0]             r_state;
  logic [MC_W-1:0]        r_mc_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic [FLUSH_CNT_W-1:0] r_flush_events;
  logic                   r_mc_timeout;

  logic       w_hazard;
  logic       w_mem_wait;
  logic [1:0] w_next;
  logic       w_freeze;
  logic       w_lu_stall;
  logic       w_br_flush;
  logic       w_cnt_clr;
  logic       w_cnt_inc;
  logic       w_to_set;
  logic       w_pc_en;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
    .i_ex_mem_read (bus.ex_mem_read),
    .i_ex_rd       (bus.ex_rd),
    .i_id_rs1      (bus.id_rs1),
    .i_id_rs2      (bus.id_rs2),
    .i_id_uses_rs1 (bus.id_uses_rs1),
    .i_id_uses_rs2 (bus.id_uses_rs2),
    .o_hazard      (w_hazard)
  );

  assign w_mem_wait = bus.mem_req && !bus.mem_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_next     = r_state;
    w_freeze   = 1'b0;
    w_lu_stall = 1'b0;
    w_br_flush = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_to_set   = 1'b0;
    case (r_state)
      S_MC_BUSY: begin
        // A memory wait here is ignored: the pipe is already frozen and RUN re-evaluates it.
        if (bus.mc_done) begin
          w_next = S_RUN;
        end else if (r_mc_cnt == MC_LAST) begin
          w_next   = S_RUN;
          w_to_set = 1'b1;
        end else begin
          w_freeze  = 1'b1;
          w_cnt_inc = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (bus.mem_ready) w_next = S_RUN;
        else               w_freeze = 1'b1;
      end
      default: begin
        w_next = S_RUN;
        if (w_mem_wait) begin
          w_freeze = 1'b1;
          w_next   = S_MEM_WAIT;
        end else if (bus.ex_mc_start) begin
          w_freeze  = 1'b1;
          w_next    = S_MC_BUSY;
          w_cnt_clr = 1'b1;
        end else if (bus.ex_branch_taken) begin
          w_br_flush = 1'b1;
        end else if (w_hazard) begin
          w_lu_stall = 1'b1;
        end
      end
    endcase
  end

  // Everything is forced low while reset is held, independent of the clock.
  assign w_pc_en          = reset && !w_freeze && !w_lu_stall;
  assign bus.pc_en        = w_pc_en;
  assign bus.if_id_en     = w_pc_en;
  assign bus.id_ex_en     = reset && !w_freeze;
  assign bus.ex_mem_en    = reset && !w_freeze;
  assign bus.mem_wb_en    = reset;
  assign bus.if_id_flush  = reset && w_br_flush;
  assign bus.id_ex_flush  = reset && (w_br_flush || w_lu_stall);
  assign bus.mem_wb_flush = reset && w_freeze;
  assign bus.ctrl_state   = r_state;
  assign bus.mc_timeout   = r_mc_timeout;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_events = r_flush_events;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_RUN;
      r_mc_cnt       <= '0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
      r_mc_timeout   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state <= w_next;
      if (w_cnt_clr)      r_mc_cnt <= '0;
      else if (w_cnt_inc) r_mc_cnt <= r_mc_cnt + MC_W'(1);
      if (!w_pc_en && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
      if (w_br_flush && (r_flush_events != '1))
        r_flush_events <= r_flush_events + FLUSH_CNT_W'(1);
      if (w_to_set) r_mc_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; expectations queued per cycle and checked mid-cycle.
module tb_pipeline_stall_controller;
  import pipe_ctrl_pkg::*;

  // Short timeout keeps the abort path reachable in a few dozen cycles.
  localparam int MC_TO = 12;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipeline_stall_controller_if b ();

  pipeline_stall_controller #(.MC_TIMEOUT(MC_TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  typedef struct {
    logic [4:0]  en;    // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0]  fl;    // {if_id, id_ex, mem_wb}
    logic [1:0]  st;
    logic [31:0] stall;
    logic [15:0] fev;
    logic        to;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] e_stall;
  logic [15:0] e_fev;
  logic        e_to;

  function automatic logic [4:0] obs_en();
    return {b.pc_en, b.if_id_en, b.id_ex_en, b.ex_mem_en, b.mem_wb_en};
  endfunction

  function automatic logic [2:0] obs_fl();
    return {b.if_id_flush, b.id_ex_flush, b.mem_wb_flush};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic mr, input logic [4:0] rd, input logic br,
                       input logic mcs, input logic mcd, input logic mreq, input logic mrdy);
    b.id_rs1 = rs1; b.id_rs2 = rs2; b.id_uses_rs1 = u1; b.id_uses_rs2 = u2;
    b.ex_mem_read = mr; b.ex_rd = rd; b.ex_branch_taken = br;
    b.ex_mc_start = mcs; b.mc_done = mcd; b.mem_req = mreq; b.mem_ready = mrdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input logic [4:0] en, input logic [2:0] fl, input logic [1:0] st);
    exp_t e;
    e.en = en; e.fl = fl; e.st = st;
    e.stall = e_stall; e.fev = e_fev; e.to = e_to;
    sb_q.push_back(e);
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    check({tag, ".en"},    32'(obs_en()),       32'(e.en));
    check({tag, ".flush"}, 32'(obs_fl()),       32'(e.fl));
    check({tag, ".state"}, 32'(b.ctrl_state),   32'(e.st));
    check({tag, ".stall"}, b.stall_cycles,      e.stall);
    check({tag, ".flushes"}, 32'(b.flush_events), 32'(e.fev));
    check({tag, ".timeout"}, 32'(b.mc_timeout), 32'(e.to));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag, input logic [4:0] en, input logic [2:0] fl,
                      input logic [1:0] st);
    push_exp(en, fl, st);
    #2;
    compare_front(tag);
    if (!en[4]) e_stall = e_stall + 32'd1;
    if (fl[2])  e_fev   = e_fev + 16'd1;
    @(negedge clk);
  endtask

  initial begin
    e_stall = '0; e_fev = '0; e_to = 1'b0;
    idle();
    #1;
    push_exp(5'b00000, 3'b000, 2'd0);
    compare_front("reset");
    @(negedge clk);
    reset = 1'b1;
    step("idle", 5'b11111, 3'b000, 2'd0);

    // Load-use detection and its non-hazard variants.
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rs1", 5'b00111, 3'b010, 2'd0);
    drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_x0", 5'b11111, 3'b000, 2'd0);
    drive(5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rs2", 5'b00111, 3'b010, 2'd0);
    drive(5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_unused", 5'b11111, 3'b000, 2'd0);
    drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_noload", 5'b11111, 3'b000, 2'd0);

    // Taken branch suppresses a simultaneous load-use stall.
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("br_lu", 5'b11111, 3'b110, 2'd0);
    idle();
    step("post_br", 5'b11111, 3'b000, 2'd0);

    // Multicycle op: ten busy cycles, memory wait inside MC_BUSY must not leave it.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("mc_start", 5'b00001, 3'b001, 2'd0);
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i >= 3 && i <= 5) begin b.mem_req = 1'b1; b.mem_ready = 1'b0; end
      step("mc_busy", 5'b00001, 3'b001, 2'd1);
    end
    idle();
    b.mc_done = 1'b1;
    step("mc_done", 5'b11111, 3'b000, 2'd1);
    idle();
    step("mc_ret", 5'b11111, 3'b000, 2'd0);

    // mc_done on the timeout cycle wins: no flag.
    b.ex_mc_start = 1'b1;
    step("mcd_start", 5'b00001, 3'b001, 2'd0);
    idle();
    for (int i = 0; i < MC_TO - 1; i++) step("mcd_busy", 5'b00001, 3'b001, 2'd1);
    b.mc_done = 1'b1;
    step("mcd_last", 5'b11111, 3'b000, 2'd1);
    idle();
    step("mcd_ret", 5'b11111, 3'b000, 2'd0);

    // Timeout abort and sticky flag.
    b.ex_mc_start = 1'b1;
    step("to_start", 5'b00001, 3'b001, 2'd0);
    idle();
    for (int i = 0; i < MC_TO - 1; i++) step("to_busy", 5'b00001, 3'b001, 2'd1);
    step("to_fire", 5'b11111, 3'b000, 2'd1);
    e_to = 1'b1;
    step("to_ret", 5'b11111, 3'b000, 2'd0);
    step("to_sticky", 5'b11111, 3'b000, 2'd0);

    // Memory wait: ready low for three cycles, then high.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mw_enter", 5'b00001, 3'b001, 2'd0);
    step("mw_wait", 5'b00001, 3'b001, 2'd2);
    step("mw_wait", 5'b00001, 3'b001, 2'd2);
    b.mem_ready = 1'b1;
    step("mw_done", 5'b11111, 3'b000, 2'd2);
    idle();
    step("mw_ret", 5'b11111, 3'b000, 2'd0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("mw_ready_now", 5'b11111, 3'b000, 2'd0);

    // Memory wait outranks multicycle start, branch and load-use in the same cycle.
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("prio", 5'b00001, 3'b001, 2'd0);
    idle();
    b.mem_req = 1'b1; b.mem_ready = 1'b1;
    step("prio_done", 5'b11111, 3'b000, 2'd2);
    idle();
    step("prio_ret", 5'b11111, 3'b000, 2'd0);

    // Asynchronous reset between clock edges while in MC_BUSY.
    b.ex_mc_start = 1'b1;
    step("rst_mc_start", 5'b00001, 3'b001, 2'd0);
    idle();
    step("rst_mc_busy", 5'b00001, 3'b001, 2'd1);
    #3;
    reset = 1'b0;
    #1;
    e_stall = '0; e_fev = '0; e_to = 1'b0;
    push_exp(5'b00000, 3'b000, 2'd0);
    compare_front("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step("rst_rel", 5'b11111, 3'b000, 2'd0);
    step("rst_rel2", 5'b11111, 3'b000, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central sequencer for the pipeline-register enables/flushes (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage core. Detects load-use hazards, holds the pipe for multicycle EX ops and data-memory wait states, and squashes wrong-path instructions on taken branches. Keeps saturating stall/flush performance counters and flags multicycle-op timeouts.

Parameters:
REG_ADDR_W, 5, register-index width
MC_TIMEOUT, 64, max cycles in MC_BUSY before forced abort
STALL_CNT_W, 32, stall-cycle counter width
FLUSH_CNT_W, 16, flush-event counter width

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset (low = in reset)
id_rs1, id_rs2  in  REG_ADDR_W  source registers of instruction in ID
id_uses_rs1, id_uses_rs2  in  1  source actually read
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  REG_ADDR_W  destination of instruction in EX
ex_branch_taken  in  1  branch/jump in EX resolved taken
ex_mc_start  in  1  multicycle op (mul/div) entering execution this cycle
mc_done  in  1  multicycle unit result valid
mem_req  in  1  MEM stage accessing data memory
mem_ready  in  1  data memory completes access this cycle
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register enables
if_id_flush, id_ex_flush, mem_wb_flush  out  1  load bubble (zero) into register
ctrl_state  out  2  current FSM state
mc_timeout  out  1  sticky error flag
stall_cycles  out  STALL_CNT_W  cycles with pc_en=0
flush_events  out  FLUSH_CNT_W  taken-branch flushes

Behaviour:
- Reset low (async): state=RUN, counters=0, mc_timeout=0; all *_en=0, all *_flush=0 while reset low. Reset mid-MC_BUSY/MEM_WAIT aborts immediately.
- States: RUN=0, MC_BUSY=1, MEM_WAIT=2 (3 unused, decodes as RUN).
- Enables/flushes are combinational from state+inputs (zero latency); state/counters/mc_timeout registered on posedge clk.
- Priority in RUN (highest first): mem wait > multicycle start > branch flush > load-use > normal.
- Mem wait (mem_req && !mem_ready): pc/if_id/id_ex/ex_mem_en=0, mem_wb_flush=1; next=MEM_WAIT. In MEM_WAIT same outputs; on mem_ready: all enables 1, next=RUN.
- ex_mc_start: pc/if_id/id_ex/ex_mem_en=0, mem_wb_flush=1; next=MC_BUSY, timeout counter=0. In MC_BUSY same outputs, counter++; mc_done: all enables 1, next=RUN; counter reaching MC_TIMEOUT-1 without mc_done: set mc_timeout (sticky until reset), enables 1, next=RUN. mc_done and timeout same cycle: mc_done wins, no flag.
- mem_req && !mem_ready during MC_BUSY: remain MC_BUSY (already frozen); mem wait evaluated on return to RUN.
- Branch taken (RUN): all enables 1, if_id_flush=1, id_ex_flush=1; flush_events++.
- Load-use: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)): pc_en=if_id_en=0, id_ex_flush=1, others enabled. Single cycle; no state change. Suppressed when branch taken same cycle.
- Flush asserted -> corresponding enable also 1 (flush overrides hold).
- stall_cycles increments every cycle pc_en=0 (reset excluded); both counters saturate at all-ones.

Decomposition:
- Package pipe_ctrl_pkg: ctrl_state_t enum {RUN, MC_BUSY, MEM_WAIT}, REG_ADDR_W default, x0 index constant.
- Sub-module load_use_detect: purely combinational hazard compare producing one hazard bit.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> same cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles 0->1; ex_rd=0 variant -> no stall.
- Branch + load-use same cycle: ex_branch_taken=1 with hazard -> pc_en=1, if_id_flush=id_ex_flush=1, flush_events=1, stall_cycles unchanged.
- Multicycle: ex_mc_start pulse, mc_done after 10 cycles -> ctrl_state=1 for 10 cycles, mem_wb_flush=1 throughout, stall_cycles=11, then RUN.
- Timeout: MC_TIMEOUT=8, ex_mc_start, never mc_done -> mc_timeout=1 after 8 cycles, state=RUN, flag stays set.
- Memory wait: mem_req=1, mem_ready low 3 cycles then high -> state=2 for 3 cycles, ex_mem_en=0, return RUN with all enables 1.
- Async reset low mid-MC_BUSY (between clock edges) -> ctrl_state=0, counters=0, all outputs 0 immediately; release -> normal RUN enables.
